fa_serial_ctrl: RTL
===================

Name: fa_serial_ctrl

Overview:
- Bit-serial add/subtract sequencer built around a single one-bit full-adder cell (FA).
- Accepts two WIDTH-bit operands over a valid/ready handshake and feeds them LSB-first through the FA, one bit per clock, with a registered carry.
- Returns the result, carry-out and signed overflow over a second valid/ready handshake.
- Serves as the low-area arithmetic resource for SC-CGRA PE configurations that trade latency for area.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- CNT_W, $clog2(WIDTH), bit-counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept operands.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- op_sub  in  1  1 = A−B, 0 = A+B; sampled at accept.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum/difference, modulo 2^WIDTH.
- carry_out  out  1  final carry; for subtract, 1 = no borrow.
- overflow  out  1  two's-complement signed overflow.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - result=0, carry_out=0, overflow=0.
  - Shift registers, counter and carry register cleared.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&in_ready: latch op_a into shift reg A; latch op_b, or ~op_b if op_sub, into shift reg B.
  - Carry reg = op_sub. Counter=0. Go to RUN.
- RUN (in_ready=0):
  - FA inputs are a=A[0], b=B[0], cin=carry reg.
  - Each edge: shift A and B right by one; shift FA sum into result shift reg MSB (result fills LSB-first from the top); carry reg ← FA cout; counter++.
  - When counter==WIDTH−1 on an edge, also record overflow = carry reg (carry into MSB) XOR FA cout. Then go to DONE.
  - RUN therefore lasts exactly WIDTH cycles.
- Latency: out_valid rises at the edge WIDTH clocks after the accepting edge.
- DONE:
  - out_valid=1. result, carry_out (= carry reg) and overflow are held stable while out_ready=0.
  - On an edge with out_valid&out_ready: out_valid←0, go to IDLE.
  - No accept is possible in the same cycle, so minimum initiation interval = WIDTH+2 cycles.
- Outputs are registered. result, carry_out and overflow keep their last values after the handshake until the next DONE entry. Only out_valid qualifies them.
- Operand changes on op_a/op_b/op_sub outside an accept cycle are ignored.
- in_valid during RUN/DONE is ignored. The requester must hold it until in_ready is high.
- out_ready asserted while out_valid=0 has no effect.
- Reset mid-RUN or mid-DONE: immediate return to reset values; partial result is discarded; no out_valid is produced.
- WIDTH=2 must work: RUN lasts 2 cycles.

Test Plan (WIDTH=8):
1. Add 0x5A+0x3C, out_ready=1 → out_valid exactly 8 clocks after accept; result=0x96, carry_out=0, overflow=1; in_ready high again the cycle after handshake.
2. Add 0xFF+0x01 → result=0x00, carry_out=1, overflow=0.
3. Sub 0x10−0x20 → result=0xF0, carry_out=0 (borrow), overflow=0. Sub 0x80−0x01 → result=0x7F, carry_out=1, overflow=1.
4. Backpressure: complete an op with out_ready=0 for 5 cycles, toggling op_a/op_b and holding in_valid=1 → result/flags stable, out_valid=1, in_ready=0, busy=1 throughout. Handshake then returns to IDLE, and the next pending op is accepted one cycle later.
5. Reset asserted asynchronously at RUN bit 4 → all outputs go to reset values immediately (no clock edge needed), no out_valid follows; then a new op 0x01+0x01 yields 0x02.
6. Back-to-back stream of 20 random add/sub ops with random in_valid/out_ready gaps, compared against a reference model (A±B mod 256, carry, signed overflow) → zero mismatches; every result delivered exactly once, in order.

Source files
------------

// File: rtl/fa_serial_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell, LSB-first, registered carry.
module fa_serial_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   sh_a;
  logic [WIDTH-1:0]   sh_b;
  logic [WIDTH-1:0]   res_sh;
  logic [WIDTH-1:0]   res_next;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt;

  logic               accept_c;
  logic               last_c;
  logic               fa_a;
  logic               fa_b;
  logic               fa_sum;
  logic               fa_cout;

  // Single full-adder cell fed from the operand shift registers and carry register
  always_comb begin
    fa_a    = sh_a[0];
    fa_b    = sh_b[0];
    fa_sum  = fa_a ^ fa_b ^ carry_q;
    fa_cout = (fa_a & fa_b) | (carry_q & (fa_a ^ fa_b));
  end

  // Result shift register fills from the top, so the final bit lands in place
  assign res_next = WIDTH'({fa_sum, res_sh} >> 1);

  assign accept_c = (state_q == IDLE) && in_valid && in_ready;
  assign last_c   = (state_q == RUN) && (cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand load on accept, one bit per clock in RUN, outputs captured on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a      <= '0;
      sh_b      <= '0;
      res_sh    <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept_c) begin
      sh_a    <= op_a;
      sh_b    <= op_sub ? ~op_b : op_b;
      carry_q <= op_sub;
      cnt     <= '0;
    end else if (state_q == RUN) begin
      sh_a    <= sh_a >> 1;
      sh_b    <= sh_b >> 1;
      res_sh  <= res_next;
      carry_q <= fa_cout;
      cnt     <= cnt + CNT_W'(1);
      if (last_c) begin
        result    <= res_next;
        carry_out <= fa_cout;
        overflow  <= carry_q ^ fa_cout;
      end
    end
  end

  // Registered handshake/status outputs derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

endmodule
